iq_zip_sequencer: RTL
=====================

IQ_ZIP_SEQUENCER -- requirements
Module: iq_zip_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: input/output word width; I = i_tdata[31:16], Q = i_tdata[15:0], both signed two's complement.
REQ-002 SHALL have parameter MAX_SHIFT, default 12: highest legal nibble-select position.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port shift  input  4  nibble select; each component contributes bits [shift+3:shift]; values above MAX_SHIFT are clamped to MAX_SHIFT.
REQ-006 SHALL have ports i_tdata/i_tlast/i_tvalid/i_tready  in/in/in/out  WIDTH/1/1/1  AXI-Stream sample input, one IQ symbol per beat.
REQ-007 SHALL have ports o_tdata/o_tlast/o_tvalid/o_tready  out/out/out/in  WIDTH/1/1/1  AXI-Stream packed output.
REQ-008 SHALL have port lane  output  2  current fill position of the pack register (0..3).

Function
REQ-009 SHALL map each accepted symbol to one byte {I_nibble, Q_nibble}, with I in bits [7:4].
REQ-010 SHALL pack symbol k (k = 0..3, arrival order) into o_tdata[31-8k:24-8k], so the first symbol lands in the MSB byte.
REQ-011 SHALL keep a lane counter: increment on each input handshake (i_tvalid & i_tready), wrap 3->0.
REQ-012 SHALL complete a group when the accepted beat has lane==3 or i_tlast==1.
REQ-013 On group completion, SHALL copy the pack register, including the current byte, to the output register, reset lane to 0, and assert o_tvalid on the next cycle (latency: 1 clock after the completing beat).
REQ-014 SHALL fill unused bytes of a partial group (early i_tlast) with 8'h00 and SHALL set o_tlast=1 for that word.
REQ-015 SHALL set o_tlast=1 only on words completed by an i_tlast beat, including a full group whose 4th beat carries i_tlast.
REQ-016 SHALL drive i_tready = ~o_tvalid | o_tready (combinational); input never stalls while the output register is empty or draining.
REQ-017 SHALL sustain one input per cycle; a group completing in the same cycle as an output handshake loads the output register with no bubble.
REQ-018 SHALL hold o_tdata and o_tlast stable while o_tvalid & ~o_tready.
REQ-019 SHALL clear o_tvalid after an output handshake unless a new group completes in that same cycle.
REQ-020 SHALL sample shift on each input handshake; changing shift mid-group affects only subsequent symbols.
REQ-021 SHALL implement the state as lane counter × output-valid flag:
- EMPTY: lane 0, no output pending.
- FILLING: lane 1..3.
- HOLD: o_tvalid=1.
- FILLING and HOLD may coexist.

Reset
REQ-022 While reset==0 at a clk edge, SHALL clear lane=0, o_tvalid=0, o_tlast=0, o_tdata=0 and the pack register.
REQ-023 Reset asserted mid-group or mid-HOLD SHALL discard the partial group and the pending output word without emitting them.
REQ-024 During reset, i_tready SHALL read 1 (consequence of o_tvalid=0); beats presented during reset are dropped.

Configuration
REQ-025 Macro IQ_ZIP_ROUND_EN SHALL enable rounding and saturation.
REQ-026 With IQ_ZIP_ROUND_EN defined, each component SHALL be processed as follows:
- add 2^(shift-1) when shift>0;
- take bits [shift+3:shift] of the widened sum;
- saturate to the signed range -8..+7.
REQ-027 Without IQ_ZIP_ROUND_EN, SHALL use plain truncation of bits [shift+3:shift] with no rounding logic synthesized.

Verification
REQ-028 Full group: shift=12; beats 0x10002000, 0x30004000, 0x50006000, 0x70008000 (last on 4th) -> o_tdata=0x12345678, o_tlast=1, one clock after the 4th beat.
REQ-029 Partial packet: shift=12; beats 0x10002000, 0x30004000 (tlast on 2nd) -> o_tdata=0x12340000, o_tlast=1; the next group starts at lane 0.
REQ-030 Back-pressure: o_tready=0 with a word pending -> i_tready=0 and o_tdata held; release o_tready -> word transferred and 8 streamed beats yield 2 words with no gap.
REQ-031 Shift clamp: shift=15, beat 0xA0005000 -> byte 0xA5 (treated as shift=12); shift=0, beat 0x0003000C -> byte 0x3C.
REQ-032 Round/saturate (macro defined): shift=12, I=0x0800, Q=0x7800 -> byte 0x17; macro undefined -> byte 0x07.
REQ-033 Reset mid-group: 2 beats accepted, then reset=0 for 1 cycle -> no output; next 4 beats produce exactly one word built from those 4 beats.

Source files
------------

// File: rtl/iq_zip_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : iq_zip_sequencer
// Description : Compresses IQ symbols to one {I,Q} nibble byte each and packs
//               four symbols per AXI-Stream output word. The optional
//               IQ_ZIP_ROUND_EN macro adds round-half-up and saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module iq_zip_sequencer #(
    parameter int WIDTH     = 32,
    parameter int MAX_SHIFT = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       shift,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [1:0]       lane
);

    localparam int         HALF     = WIDTH / 2;
    localparam logic [3:0] C_MAX_SH = 4'(MAX_SHIFT);

    // Reduce one signed component to a 4-bit field starting at bit sh.
    function automatic logic [3:0] to_nibble(input logic [HALF-1:0] comp,
                                             input logic [3:0]      sh);
`ifdef IQ_ZIP_ROUND_EN
        logic        [HALF:0] rnd;
        logic signed [HALF:0] sum;
        logic signed [HALF:0] q;
        rnd = ((HALF+1)'(1) << sh) >> 1;
        sum = $signed({comp[HALF-1], comp}) + $signed(rnd);
        q   = sum >>> sh;
        if (int'(q) > 7)
            return 4'h7;
        else if (int'(q) < -8)
            return 4'h8;
        else
            return q[3:0];
`else
        return 4'(comp >> sh);
`endif
    endfunction

    logic [1:0]       r_lane;
    logic [WIDTH-1:0] r_pack;
    logic [3:0]       w_sh;
    logic [7:0]       w_byte;
    logic [WIDTH-1:0] w_pack_next;
    logic             w_in_hs;
    logic             w_out_hs;
    logic             w_done;

    assign i_tready = ~o_tvalid | o_tready;
    assign lane     = r_lane;
    assign w_in_hs  = i_tvalid & i_tready;
    assign w_out_hs = o_tvalid & o_tready;
    assign w_done   = w_in_hs & ((r_lane == 2'd3) | i_tlast);

    // Pack register is cleared on every group completion, so bytes never
    // written by a short group are already zero.
    always_comb begin
        w_sh        = (shift > C_MAX_SH) ? C_MAX_SH : shift;
        w_byte      = {to_nibble(i_tdata[WIDTH-1:HALF], w_sh),
                       to_nibble(i_tdata[HALF-1:0], w_sh)};
        w_pack_next = r_pack | (WIDTH'(w_byte) << (5'd24 - {r_lane, 3'b000}));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lane   <= 2'd0;
            r_pack   <= '0;
            o_tdata  <= '0;
            o_tlast  <= 1'b0;
            o_tvalid <= 1'b0;
        end else begin
            if (w_in_hs) begin
                r_lane <= w_done ? 2'd0 : r_lane + 2'd1;
                r_pack <= w_done ? '0 : w_pack_next;
            end
            // i_tready guarantees the output slot is free or draining here.
            if (w_done) begin
                o_tdata  <= w_pack_next;
                o_tlast  <= i_tlast;
                o_tvalid <= 1'b1;
            end else if (w_out_hs) begin
                o_tvalid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
